// File: rtl/instruction_encoder_if.sv
// Request/response bundle between the program loader and the instruction encoder.
// The master side issues field requests and consumes encoded words.
interface instruction_encoder_if #(
    parameter int unsigned ADDR_WIDTH = 8
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [2:0]            fmt;
    logic [6:0]            opcode;
    logic [4:0]            rd;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [2:0]            funct3;
    logic [6:0]            funct7;
    logic [31:0]           imm;
    logic                  out_valid;
    logic                  out_ready;
    logic [31:0]           out_instr;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic                  out_err;
    logic [1:0]            err_code;

    modport master (
        output in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        input  in_ready, out_valid, out_instr, out_addr, out_err, err_code
    );

    modport slave (
        input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        output in_ready, out_valid, out_instr, out_addr, out_err, err_code
    );
endinterface

// File: rtl/instruction_encoder.sv
// Packs RV32I fields and a signed immediate into an instruction word, substituting a NOP
// for requests with bad format, misaligned or out-of-range immediates.
module instruction_encoder #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  restart,
    instruction_encoder_if.slave  bus,
    output logic [7:0]            err_cnt
);

    localparam logic [ADDR_WIDTH-1:0] BaseAddr = ADDR_WIDTH'(BASE_ADDR);
    localparam logic [31:0]           Nop      = 32'h0000_0013;

    typedef enum logic {StEmpty, StFull} state_e;

    state_e                state_q, state_d;
    logic [31:0]           out_instr_q;
    logic [ADDR_WIDTH-1:0] out_addr_q;
    logic                  out_err_q;
    logic [1:0]            err_code_q;
    logic [ADDR_WIDTH-1:0] addr_cnt_q, addr_cnt_d, addr_base;
    logic [7:0]            err_cnt_q, err_cnt_d;

    logic                  in_hs, out_hs;
    logic signed [31:0]    simm;
    logic [31:0]           enc_instr;
    logic                  range_ok, misaligned, bad_fmt;
    logic [1:0]            enc_code;

    assign simm = $signed(bus.imm);

    always_comb begin
        enc_instr  = '0;
        range_ok   = 1'b1;
        misaligned = 1'b0;
        bad_fmt    = 1'b0;
        case (bus.fmt)
            3'd0: enc_instr = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
            3'd1: begin
                enc_instr = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
                range_ok  = (simm >= -32'sd2048) && (simm <= 32'sd2047);
            end
            3'd2: begin
                enc_instr = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0],
                             bus.opcode};
                range_ok  = (simm >= -32'sd2048) && (simm <= 32'sd2047);
            end
            3'd3: begin
                enc_instr  = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                              bus.imm[4:1], bus.imm[11], bus.opcode};
                range_ok   = (simm >= -32'sd4096) && (simm <= 32'sd4094);
                misaligned = bus.imm[0];
            end
            3'd4: begin
                enc_instr = {bus.imm[31:12], bus.rd, bus.opcode};
                // Upper immediates carrying low bits cannot be represented.
                range_ok  = (bus.imm[11:0] == 12'd0);
            end
            3'd5: begin
                enc_instr  = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12], bus.rd,
                              bus.opcode};
                range_ok   = (simm >= -32'sd1048576) && (simm <= 32'sd1048574);
                misaligned = bus.imm[0];
            end
            default: bad_fmt = 1'b1;
        endcase

        if (bad_fmt) begin
            enc_code = 2'd3;
        end else if (misaligned) begin
            enc_code = 2'd2;
        end else if (!range_ok) begin
            enc_code = 2'd1;
        end else begin
            enc_code = 2'd0;
        end
    end

    assign bus.out_valid = (state_q == StFull);
    assign bus.in_ready  = (state_q == StEmpty) || bus.out_ready;
    assign in_hs         = bus.in_valid && bus.in_ready;
    assign out_hs        = bus.out_valid && bus.out_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StEmpty: if (in_hs) state_d = StFull;
            StFull:  if (out_hs && !in_hs) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase
    end

    // restart takes effect before the accept so the accepted word lands on BaseAddr.
    always_comb begin
        addr_base  = restart ? BaseAddr : addr_cnt_q;
        addr_cnt_d = in_hs ? addr_base + 1'b1 : addr_base;
        err_cnt_d  = err_cnt_q;
        if (restart) begin
            err_cnt_d = '0;
        end else if (out_hs && out_err_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StEmpty;
            out_instr_q <= '0;
            out_addr_q  <= BaseAddr;
            out_err_q   <= 1'b0;
            err_code_q  <= 2'd0;
            addr_cnt_q  <= BaseAddr;
            err_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            addr_cnt_q <= addr_cnt_d;
            err_cnt_q  <= err_cnt_d;
            if (in_hs) begin
                out_instr_q <= (enc_code != 2'd0) ? Nop : enc_instr;
                out_addr_q  <= addr_base;
                out_err_q   <= (enc_code != 2'd0);
                err_code_q  <= enc_code;
            end
        end
    end

    assign bus.out_instr = out_instr_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_err   = out_err_q;
    assign bus.err_code  = err_code_q;
    assign err_cnt       = err_cnt_q;

endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench for instruction_encoder: an 8-bit-address instance for encoding and
// error checks, and a 2-bit-address instance for wrap, restart and reset-while-full.
module tb_instruction_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst8, rst2, restart8, restart2;
    logic [7:0] err_cnt8, err_cnt2;

    logic [2:0]  fmt;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic        in_valid8, in_valid2, out_ready8, out_ready2;

    instruction_encoder_if #(.ADDR_WIDTH(8)) bus8 ();
    instruction_encoder_if #(.ADDR_WIDTH(2)) bus2 ();

    assign bus8.in_valid  = in_valid8;
    assign bus8.out_ready = out_ready8;
    assign bus8.fmt       = fmt;
    assign bus8.opcode    = opcode;
    assign bus8.rd        = rd;
    assign bus8.rs1       = rs1;
    assign bus8.rs2       = rs2;
    assign bus8.funct3    = funct3;
    assign bus8.funct7    = funct7;
    assign bus8.imm       = imm;
    assign bus2.in_valid  = in_valid2;
    assign bus2.out_ready = out_ready2;
    assign bus2.fmt       = fmt;
    assign bus2.opcode    = opcode;
    assign bus2.rd        = rd;
    assign bus2.rs1       = rs1;
    assign bus2.rs2       = rs2;
    assign bus2.funct3    = funct3;
    assign bus2.funct7    = funct7;
    assign bus2.imm       = imm;

    instruction_encoder #(.ADDR_WIDTH(8), .BASE_ADDR(0)) dut8 (
        .clk     (clk),
        .rst     (rst8),
        .restart (restart8),
        .bus     (bus8.slave),
        .err_cnt (err_cnt8)
    );

    instruction_encoder #(.ADDR_WIDTH(2), .BASE_ADDR(0)) dut2 (
        .clk     (clk),
        .rst     (rst2),
        .restart (restart2),
        .bus     (bus2.slave),
        .err_cnt (err_cnt2)
    );

    typedef struct {
        logic [31:0] instr;
        logic [7:0]  addr;
        logic        err;
        logic [1:0]  code;
    } exp_t;

    exp_t       q8[$], q2[$];
    exp_t       e8, e2;
    int         n_checks = 0, n_fail = 0;
    int         hs8 = 0, hs2 = 0;
    logic [7:0] addr8 = 8'd0;
    logic [1:0] addr2 = 2'd0;

    localparam logic [6:0] OpImm = 7'b0010011, OpSt = 7'b0100011, OpBr = 7'b1100011;
    localparam logic [6:0] OpLui = 7'b0110111, OpJal = 7'b1101111, OpReg = 7'b0110011;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    always @(negedge clk) begin
        if (!rst8 && bus8.out_valid && out_ready8) begin
            hs8++;
            if (q8.size() == 0) begin
                fail_now("dut8 unexpected output word");
            end else begin
                e8 = q8.pop_front();
                check("dut8 out_instr", bus8.out_instr, e8.instr);
                check("dut8 out_addr", 32'(bus8.out_addr), 32'(e8.addr));
                check("dut8 out_err", 32'(bus8.out_err), 32'(e8.err));
                check("dut8 err_code", 32'(bus8.err_code), 32'(e8.code));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst2 && bus2.out_valid && out_ready2) begin
            hs2++;
            if (q2.size() == 0) begin
                fail_now("dut2 unexpected output word");
            end else begin
                e2 = q2.pop_front();
                check("dut2 out_instr", bus2.out_instr, e2.instr);
                check("dut2 out_addr", 32'(bus2.out_addr), 32'(e2.addr));
                check("dut2 out_err", 32'(bus2.out_err), 32'(e2.err));
                check("dut2 err_code", 32'(bus2.err_code), 32'(e2.code));
            end
        end
    end

    task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                           input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [31:0] im);
        fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input bit sel, input logic [2:0] f, input logic [6:0] op,
                         input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im,
                         input logic [31:0] ex_instr, input logic [1:0] ex_code);
        exp_t e;
        bit   ok = 1'b0;
        set_req(f, op, d, s1, s2, f3, f7, im);
        if (sel) in_valid2 = 1'b1; else in_valid8 = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (sel ? bus2.in_ready : bus8.in_ready) begin
                ok      = 1'b1;
                e.instr = ex_instr;
                e.code  = ex_code;
                e.err   = (ex_code != 2'd0);
                if (sel) begin
                    e.addr = {6'd0, addr2};
                    addr2  = addr2 + 2'd1;
                    q2.push_back(e);
                end else begin
                    e.addr = addr8;
                    addr8  = addr8 + 8'd1;
                    q8.push_back(e);
                end
                break;
            end
        end
        if (!ok) fail_now("issue timeout waiting for in_ready");
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        in_valid2 = 1'b0;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (q8.size() == 0 && q2.size() == 0) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) fail_now("drain timeout, words missing");
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs_before;
        logic [7:0] held_addr;
        rst8 = 1'b1; rst2 = 1'b1; restart8 = 1'b0; restart2 = 1'b0;
        in_valid8 = 1'b0; in_valid2 = 1'b0; out_ready8 = 1'b1; out_ready2 = 1'b1;
        set_req(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
        #12;
        check("reset in_ready", 32'(bus8.in_ready), 32'd1);
        check("reset out_valid", 32'(bus8.out_valid), 32'd0);
        check("reset out_instr", bus8.out_instr, 32'd0);
        check("reset out_addr", 32'(bus8.out_addr), 32'd0);
        check("reset out_err", 32'(bus8.out_err), 32'd0);
        check("reset err_code", 32'(bus8.err_code), 32'd0);
        check("reset err_cnt", 32'(err_cnt8), 32'd0);
        rst8 = 1'b0; rst2 = 1'b0;
        @(posedge clk); #1;

        // Legal encodings, issued back to back.
        hs_before = hs8;
        issue(0, 3'd1, OpImm, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 2'd0);
        issue(0, 3'd2, OpSt, 5'd0, 5'd2, 5'd1, 3'd2, 7'd0, 32'hFFFF_FFF8, 32'hFE11_2C23, 2'd0);
        issue(0, 3'd3, OpBr, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFF8, 32'hFE20_8CE3, 2'd0);
        issue(0, 3'd4, OpLui, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_50B7, 2'd0);
        issue(0, 3'd5, OpJal, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h0010_006F, 2'd0);
        @(negedge clk); #1;
        check("back-to-back handshakes", 32'(hs8 - hs_before), 32'd5);
        @(posedge clk); #1;
        issue(0, 3'd0, OpReg, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hDEAD_BEEF, 32'h4020_81B3, 2'd0);
        issue(0, 3'd1, OpImm, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2047, 32'h7FF0_0093, 2'd0);
        issue(0, 3'd1, OpImm, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd2048, 32'h8000_0093, 2'd0);
        issue(0, 3'd3, OpBr, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4094, 32'h7E20_8FE3, 2'd0);
        issue(0, 3'd3, OpBr, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd4096, 32'h8020_8063, 2'd0);
        issue(0, 3'd5, OpJal, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1048574, 32'h7FFF_F06F, 2'd0);

        // Error substitutes.
        issue(0, 3'd1, OpImm, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h13, 2'd1);
        issue(0, 3'd3, OpBr, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 32'h13, 2'd2);
        issue(0, 3'd7, OpImm, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'h13, 2'd3);
        drain();
        check("err_cnt after three errors", 32'(err_cnt8), 32'd3);
        issue(0, 3'd2, OpSt, 5'd0, 5'd2, 5'd1, 3'd2, 7'd0, -32'sd2049, 32'h13, 2'd1);
        issue(0, 3'd3, OpBr, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd4096, 32'h13, 2'd1);
        issue(0, 3'd5, OpJal, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1048576, 32'h13, 2'd1);
        issue(0, 3'd4, OpLui, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 32'h13, 2'd1);
        issue(0, 3'd5, OpJal, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h13, 2'd2);
        issue(0, 3'd5, OpJal, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h7FFF_FFFF, 32'h13, 2'd2);
        issue(0, 3'd6, OpBr, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h13, 2'd3);
        drain();
        check("err_cnt after ten errors", 32'(err_cnt8), 32'd10);

        // Backpressure: first word held, second request stalled.
        out_ready8 = 1'b0;
        held_addr = addr8;
        issue(0, 3'd1, OpImm, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 2'd0);
        set_req(3'd2, OpSt, 5'd0, 5'd2, 5'd1, 3'd2, 7'd0, 32'hFFFF_FFF8);
        in_valid8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall in_ready", 32'(bus8.in_ready), 32'd0);
            check("stall out_valid", 32'(bus8.out_valid), 32'd1);
            check("stall out_instr", bus8.out_instr, 32'hFFF0_0093);
            check("stall out_addr", 32'(bus8.out_addr), 32'(held_addr));
        end
        @(posedge clk); #1;
        out_ready8 = 1'b1;
        issue(0, 3'd2, OpSt, 5'd0, 5'd2, 5'd1, 3'd2, 7'd0, 32'hFFFF_FFF8, 32'hFE11_2C23, 2'd0);
        drain();

        // Saturating error counter; address counter wraps through 255 on the way.
        for (int i = 0; i < 250; i++) begin
            issue(0, 3'd7, OpImm, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'h13, 2'd3);
        end
        drain();
        check("err_cnt saturated", 32'(err_cnt8), 32'd255);

        restart8 = 1'b1;
        @(posedge clk); #1;
        restart8 = 1'b0;
        addr8 = 8'd0;
        check("err_cnt cleared by restart", 32'(err_cnt8), 32'd0);
        issue(0, 3'd1, OpImm, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2047, 32'h7FF0_0093, 2'd0);
        addr8 = 8'd0;
        restart8 = 1'b1;
        issue(0, 3'd1, OpImm, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0093, 2'd0);
        restart8 = 1'b0;
        issue(0, 3'd4, OpLui, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_50B7, 2'd0);
        drain();

        // Narrow address counter wraps, then restarts.
        for (int i = 0; i < 5; i++) begin
            issue(1, 3'd1, OpImm, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 32'hFFF0_0093,
                  2'd0);
        end
        drain();
        restart2 = 1'b1;
        @(posedge clk); #1;
        restart2 = 1'b0;
        addr2 = 2'd0;
        issue(1, 3'd7, OpImm, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'h13, 2'd3);
        drain();
        check("dut2 err_cnt", 32'(err_cnt2), 32'd1);

        // Reset while holding an error word drops it at once.
        out_ready2 = 1'b0;
        issue(1, 3'd7, OpImm, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'h13, 2'd3);
        check("dut2 full before reset", 32'(bus2.out_valid), 32'd1);
        rst2 = 1'b1;
        #1;
        check("rst out_valid", 32'(bus2.out_valid), 32'd0);
        check("rst in_ready", 32'(bus2.in_ready), 32'd1);
        check("rst out_instr", bus2.out_instr, 32'd0);
        check("rst out_addr", 32'(bus2.out_addr), 32'd0);
        check("rst out_err", 32'(bus2.out_err), 32'd0);
        check("rst err_code", 32'(bus2.err_code), 32'd0);
        check("rst err_cnt", 32'(err_cnt2), 32'd0);
        q2.delete();
        @(posedge clk); #1;
        rst2 = 1'b0;
        out_ready2 = 1'b1;
        addr2 = 2'd0;
        issue(1, 3'd3, OpBr, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFF8, 32'hFE20_8CE3, 2'd0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Packs RISC-V RV32I instruction fields and a full 32-bit signed immediate into a 32-bit instruction word. It is the inverse of the immediate generator: it scatters immediate bits into the I/S/B/U/J layouts and checks range and alignment. It sits between the test/boot program loader and instruction memory. Each accepted request becomes one output word tagged with an auto-incrementing word address.

## Interface
Parameters:
- ADDR_WIDTH, 8: width of output word address.
- BASE_ADDR, 0: address loaded on reset and on `restart`.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- restart  input  1  synchronous; reload address counter to BASE_ADDR and clear err_cnt. Does not affect the pipeline.
- in_valid  input  1  request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- fmt  input  3  instruction format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6 and 7 are illegal.
- opcode  input  7  placed in instr[6:0] verbatim.
- rd, rs1, rs2  input  5 each  register fields.
- funct3  input  3  function field.
- funct7  input  7  function field; R only.
- imm  input  32  signed byte offset (I/S/B/J) or full upper value (U).
- out_valid  output  1  output word valid.
- out_ready  input  1  consumer ready.
- out_instr  output  32  encoded word.
- out_addr  output  ADDR_WIDTH  word address of out_instr.
- out_err  output  1  this word is an error substitute.
- err_code  output  2  error type: 0=none, 1=range, 2=misaligned, 3=bad fmt.
- err_cnt  output  8  count of erroneous words emitted; saturates at 255.

## Operation
- Encoding, with fields not listed set to 0:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}.
  - I: {imm[11:0], rs1, funct3, rd, opcode}.
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - B: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
  - U: {imm[31:12], rd, opcode}.
  - J: {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
- Checks, with imm treated as signed 32-bit:
  - I and S: imm must lie in [-2048, 2047].
  - B: imm must lie in [-4096, 4094].
  - J: imm must lie in [-1048576, 1048574].
  - B and J: imm[0] must be 0.
  - U: imm[11:0] must be 0; a violation is a range error.
  - R: imm is ignored.
- Error priority: bad fmt, then misaligned, then range.
- On any error:
  - out_instr = 32'h00000013 (NOP).
  - out_err = 1 and err_code is set.
  - err_cnt increments when the word's output handshake completes.
- Address: out_addr is captured from the address counter when the request is accepted. The counter increments by 1 per accepted request, error words included. It wraps modulo 2^ADDR_WIDTH.
- States: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY → FULL on an input handshake.
  - FULL → EMPTY on an output handshake with no simultaneous input handshake.
  - FULL stays FULL on simultaneous input and output handshakes; the register is replaced.
- restart in the same cycle as an accept: the accepted word gets BASE_ADDR and the counter becomes BASE_ADDR+1.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, out_instr=0, out_addr=BASE_ADDR, out_err=0, err_code=0, err_cnt=0.
  - Address counter = BASE_ADDR.
- Latency: 1 cycle; a request accepted at edge N is visible on the outputs after edge N.
- in_ready = !out_valid || out_ready. This is combinational from out_ready, and gives full throughput of 1 word per cycle.
- While out_valid=1 && out_ready=0, all out_* outputs hold stable.
- Reset asserted mid-transfer drops the held word immediately. No partial state survives.
- err_cnt at 255 plus another error: stays at 255.

## Test plan
- ADDI x1,x0,-1 (fmt=1, op=0010011, rd=1, imm=-1) → out_instr=0xFFF00093 one cycle later, out_err=0, out_addr=0.
- SW x1,-8(x2) (fmt=2, op=0100011, f3=2, rs1=2, rs2=1, imm=-8) → 0xFE112C23. BEQ x1,x2,-8 (fmt=3, op=1100011) → 0xFE208CE3.
- LUI x1, imm=0x12345000 → 0x123450B7. JAL x0, imm=2048 → 0x0010006F. Back-to-back issue → out_addr 0,1,2,… with no bubbles.
- Error cases:
  - ADDI imm=2048 → out_instr=0x00000013, err_code=1.
  - BEQ imm=3 → err_code=2.
  - fmt=7 → err_code=3.
  - After these three, err_cnt=3.
- Backpressure: hold out_ready=0 for 3 cycles with a second request pending → in_ready=0, outputs stable. Release → the first word then the second word on consecutive cycles.
- ADDR_WIDTH=2: 5 requests → addresses 0,1,2,3,0. Assert restart, then issue one request → out_addr=0. Assert rst while FULL → out_valid=0 immediately and all outputs at reset values.
